// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind game core: FSM state encoding and a counter width helper.
package mastermind_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] LOAD_CODE  = 3'd0;
    localparam logic [STATE_W-1:0] LOAD_GUESS = 3'd1;
    localparam logic [STATE_W-1:0] SCORE      = 3'd2;
    localparam logic [STATE_W-1:0] REPORT     = 3'd3;
    localparam logic [STATE_W-1:0] WON        = 3'd4;
    localparam logic [STATE_W-1:0] LOST       = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        StLoadCode  = LOAD_CODE,
        StLoadGuess = LOAD_GUESS,
        StScore     = SCORE,
        StReport    = REPORT,
        StWon       = WON,
        StLost      = LOST
    } state_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mastermind_colour_count.sv
// Counts how many digits of a packed code/guess vector equal a given colour (purely combinational).
module mastermind_colour_count
    import mastermind_pkg::*;
#(
    parameter int unsigned NUM_PEGS = 4,
    parameter int unsigned COLOR_W  = 3
) (
    input  logic [NUM_PEGS*COLOR_W-1:0]     vec,
    input  logic [COLOR_W-1:0]              colour,
    output logic [cnt_width(NUM_PEGS)-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (vec[i*COLOR_W +: COLOR_W] == colour) begin
                count = count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mastermind_engine.sv
// Mastermind game core: digit entry, red/white scoring over one colour per cycle, win/loss tracking.
// Define MM_UNIQUE_CODE_EN to reject secret-code digits that repeat an already-entered digit.
module mastermind_engine
    import mastermind_pkg::*;
#(
    parameter int unsigned NUM_PEGS    = 4,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned MAX_GUESSES = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [COLOR_W-1:0]                data_in,
    input  logic                              data_valid,
    input  logic                              new_game,
    output logic [NUM_PEGS*COLOR_W-1:0]       code,
    output logic [NUM_PEGS*COLOR_W-1:0]       guess,
    output logic [$clog2(NUM_PEGS)-1:0]       entry_idx,
    output logic [cnt_width(NUM_PEGS)-1:0]    red,
    output logic [cnt_width(NUM_PEGS)-1:0]    white,
    output logic                              score_valid,
    output logic [cnt_width(MAX_GUESSES)-1:0] guess_count,
    output logic                              busy,
    output logic                              game_won,
    output logic                              game_lost,
    output logic                              code_reject
);

    localparam int unsigned NCOL   = 2 ** COLOR_W;
    localparam int unsigned CNT_W  = cnt_width(NUM_PEGS);
    localparam int unsigned GCNT_W = cnt_width(MAX_GUESSES);
    localparam int unsigned IDX_W  = $clog2(NUM_PEGS);
    localparam int unsigned CODE_W = NUM_PEGS * COLOR_W;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   guess_q, guess_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    red_q, red_d;
    logic [CNT_W-1:0]    white_q, white_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic [COLOR_W-1:0]  col_q, col_d;
    logic                score_valid_q, score_valid_d;
    logic                code_reject_q, code_reject_d;

    logic [CNT_W-1:0]    cnt_code, cnt_guess, cnt_min, red_now;
    logic                last_idx;
    logic                dup_digit;

    mastermind_colour_count #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W)
    ) u_count_code (
        .vec    (code_q),
        .colour (col_q),
        .count  (cnt_code)
    );

    mastermind_colour_count #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W)
    ) u_count_guess (
        .vec    (guess_q),
        .colour (col_q),
        .count  (cnt_guess)
    );

    assign cnt_min  = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
    assign last_idx = (idx_q == IDX_W'(NUM_PEGS - 1));

    always_comb begin
        red_now = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (code_q[i*COLOR_W +: COLOR_W] == guess_q[i*COLOR_W +: COLOR_W]) begin
                red_now = red_now + 1'b1;
            end
        end
    end

`ifdef MM_UNIQUE_CODE_EN
    // Only digits already written (index below entry_idx) take part in the duplicate check.
    always_comb begin
        dup_digit = 1'b0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if ((i < int'(idx_q)) && (code_q[i*COLOR_W +: COLOR_W] == data_in)) begin
                dup_digit = 1'b1;
            end
        end
    end
`else
    assign dup_digit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        guess_d       = guess_q;
        idx_d         = idx_q;
        red_d         = red_q;
        white_d       = white_q;
        acc_d         = acc_q;
        gcnt_d        = gcnt_q;
        col_d         = col_q;
        score_valid_d = 1'b0;
        code_reject_d = 1'b0;

        unique case (state_q)
            StLoadCode: begin
                if (data_valid) begin
                    if (dup_digit) begin
                        code_reject_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_PEGS; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                code_d[i*COLOR_W +: COLOR_W] = data_in;
                            end
                        end
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = StLoadGuess;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            StLoadGuess: begin
                if (data_valid) begin
                    for (int i = 0; i < NUM_PEGS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            guess_d[i*COLOR_W +: COLOR_W] = data_in;
                        end
                    end
                    if (idx_q == '0) begin
                        red_d   = '0;
                        white_d = '0;
                    end
                    if (last_idx) begin
                        idx_d   = '0;
                        col_d   = '0;
                        state_d = StScore;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StScore: begin
                // First colour cycle also captures red and restarts the accumulator.
                if (col_q == '0) begin
                    red_d = red_now;
                    acc_d = cnt_min;
                end else begin
                    acc_d = acc_q + cnt_min;
                end
                if (col_q == COLOR_W'(NCOL - 1)) begin
                    state_d = StReport;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StReport: begin
                white_d       = acc_q - red_q;
                score_valid_d = 1'b1;
                if (gcnt_q != GCNT_W'(MAX_GUESSES)) begin
                    gcnt_d = gcnt_q + 1'b1;
                end
                if (red_q == CNT_W'(NUM_PEGS)) begin
                    state_d = StWon;
                end else if (gcnt_d == GCNT_W'(MAX_GUESSES)) begin
                    state_d = StLost;
                end else begin
                    state_d = StLoadGuess;
                end
            end
            StWon, StLost: begin
                if (new_game) begin
                    code_d  = '0;
                    guess_d = '0;
                    red_d   = '0;
                    white_d = '0;
                    gcnt_d  = '0;
                    idx_d   = '0;
                    state_d = StLoadCode;
                end
            end
            default: state_d = StLoadCode;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StLoadCode;
            code_q        <= '0;
            guess_q       <= '0;
            idx_q         <= '0;
            red_q         <= '0;
            white_q       <= '0;
            acc_q         <= '0;
            gcnt_q        <= '0;
            col_q         <= '0;
            score_valid_q <= 1'b0;
            code_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            guess_q       <= guess_d;
            idx_q         <= idx_d;
            red_q         <= red_d;
            white_q       <= white_d;
            acc_q         <= acc_d;
            gcnt_q        <= gcnt_d;
            col_q         <= col_d;
            score_valid_q <= score_valid_d;
            code_reject_q <= code_reject_d;
        end
    end

    assign code        = code_q;
    assign guess       = guess_q;
    assign entry_idx   = idx_q;
    assign red         = red_q;
    assign white       = white_q;
    assign score_valid = score_valid_q;
    assign guess_count = gcnt_q;
    assign busy        = (state_q == StScore) || (state_q == StReport);
    assign game_won    = (state_q == StWon);
    assign game_lost   = (state_q == StLost);
    assign code_reject = code_reject_q;

endmodule

// File: tb/tb_mastermind_engine.sv
// Self-checking bench for mastermind_engine (default parameters) against a counting-based score model.
module tb_mastermind_engine;

    localparam int NP   = 4;
    localparam int CW   = 3;
    localparam int MG   = 8;
    localparam int NCOL = 8;

    typedef int dig_t [NP];

    logic        clk = 1'b0;
    logic        resetn, data_valid, new_game;
    logic [2:0]  data_in;
    logic [11:0] code, guess;
    logic [1:0]  entry_idx;
    logic [2:0]  red, white;
    logic        score_valid;
    logic [3:0]  guess_count;
    logic        busy, game_won, game_lost, code_reject;

    int n_tests = 0;
    int n_fail  = 0;

    mastermind_engine #(
        .NUM_PEGS    (NP),
        .COLOR_W     (CW),
        .MAX_GUESSES (MG)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .new_game    (new_game),
        .code        (code),
        .guess       (guess),
        .entry_idx   (entry_idx),
        .red         (red),
        .white       (white),
        .score_valid (score_valid),
        .guess_count (guess_count),
        .busy        (busy),
        .game_won    (game_won),
        .game_lost   (game_lost),
        .code_reject (code_reject)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input dig_t d);
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < NP; i++) p[i*CW +: CW] = 3'(d[i]);
        return p;
    endfunction

    // Mastermind rules: red = exact hits, white = colour overlap minus exact hits.
    function automatic void model_score(input dig_t c, input dig_t g, output int r, output int w);
        int cc [NCOL];
        int gc [NCOL];
        int total;
        r = 0;
        total = 0;
        for (int k = 0; k < NCOL; k++) begin cc[k] = 0; gc[k] = 0; end
        for (int i = 0; i < NP; i++) begin
            if (c[i] == g[i]) r++;
            cc[c[i]]++;
            gc[g[i]]++;
        end
        for (int k = 0; k < NCOL; k++) total += (cc[k] < gc[k]) ? cc[k] : gc[k];
        w = total - r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; data_valid = 1'b0; new_game = 1'b0; data_in = '0;
        tick(); tick();
        resetn = 1'b1;
    endtask

    task automatic send_digit(input int d);
        data_in = 3'(d); data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic enter(input dig_t d);
        for (int i = 0; i < NP; i++) send_digit(d[i]);
    endtask

    // Cycles from the last accepted digit to score_valid; -1 if it never came.
    task automatic wait_score(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (score_valid === 1'b1) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({code, guess, entry_idx, red, white, guess_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs got %h want 0", {code, guess, entry_idx, red, white, guess_count});
        end
        n_tests++;
        if ({score_valid, busy, game_won, game_lost, code_reject} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {score_valid, busy, game_won, game_lost, code_reject});
        end
    endtask

    task automatic test_exact_win();
        dig_t c;
        int lat;
        logic [11:0] g_before;
        c = '{1, 2, 3, 4};
        do_reset();
        enter(c);
        n_tests++;
        if (code !== pack(c)) begin
            n_fail++; $display("FAIL win_code got %h want %h", code, pack(c));
        end
        enter(c);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL win_busy got %b want 1", busy); end
        wait_score(lat);
        n_tests++;
        if (lat != NCOL + 1) begin
            n_fail++; $display("FAIL win_latency got %0d want %0d", lat, NCOL + 1);
        end
        n_tests++;
        if ({red, white, game_won, guess_count} !== {3'd4, 3'd0, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL win_score got r%0d w%0d won%b gc%0d want r4 w0 won1 gc1",
                     red, white, game_won, guess_count);
        end
        tick();
        n_tests++;
        if (score_valid !== 1'b0) begin n_fail++; $display("FAIL win_pulse got 1 want 0"); end
        g_before = guess;
        send_digit(7);
        n_tests++;
        if (guess !== g_before || entry_idx !== 2'd0) begin
            n_fail++; $display("FAIL win_ignore got %h/%0d want %h/0", guess, entry_idx, g_before);
        end
        new_game = 1'b1; tick(); new_game = 1'b0;
        n_tests++;
        if ({code, guess, red, white, guess_count, entry_idx, game_won} !== '0) begin
            n_fail++; $display("FAIL win_newgame got %h want 0",
                               {code, guess, red, white, guess_count, entry_idx, game_won});
        end
    endtask

    task automatic test_swap();
        dig_t c, g;
        int lat;
        c = '{1, 1, 2, 2};
        g = '{2, 2, 1, 1};
        do_reset();
        enter(c);
        enter(g);
        wait_score(lat);
        n_tests++;
        if ({red, white, entry_idx, game_won, game_lost} !== {3'd0, 3'd4, 2'd0, 2'b00}) begin
            n_fail++; $display("FAIL swap_score got r%0d w%0d idx%0d want r0 w4 idx0",
                               red, white, entry_idx);
        end
        new_game = 1'b1; tick(); new_game = 1'b0;
        n_tests++;
        if (code !== pack(c) || guess_count !== 4'd1) begin
            n_fail++; $display("FAIL swap_newgame_ignored got %h gc%0d want %h gc1",
                               code, guess_count, pack(c));
        end
        send_digit(5);
        n_tests++;
        if (red !== 3'd0 || white !== 3'd0 || entry_idx !== 2'd1) begin
            n_fail++; $display("FAIL swap_clear got r%0d w%0d idx%0d want r0 w0 idx1",
                               red, white, entry_idx);
        end
    endtask

    task automatic test_busy_ignore();
        dig_t c, g;
        int lat;
        c = '{1, 1, 2, 3};
        g = '{1, 4, 1, 1};
        do_reset();
        enter(c);
        enter(g);
        data_in = 3'd7; data_valid = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        data_valid = 1'b0;
        wait_score(lat);
        n_tests++;
        if (lat + 3 != NCOL + 1) begin
            n_fail++; $display("FAIL busy_latency got %0d want %0d", lat + 3, NCOL + 1);
        end
        n_tests++;
        if (guess !== pack(g) || red !== 3'd1 || white !== 3'd1) begin
            n_fail++; $display("FAIL busy_score got %h r%0d w%0d want %h r1 w1",
                               guess, red, white, pack(g));
        end
    endtask

    task automatic test_loss();
        dig_t c, g;
        int lat;
        c = '{1, 2, 3, 4};
        g = '{0, 0, 0, 0};
        do_reset();
        enter(c);
        for (int n = 1; n <= MG; n++) begin
            enter(g);
            wait_score(lat);
            n_tests++;
            if (lat != NCOL + 1 || red !== 3'd0 || white !== 3'd0 || guess_count !== 4'(n)) begin
                n_fail++; $display("FAIL loss_guess%0d got lat%0d r%0d w%0d gc%0d want lat9 r0 w0 gc%0d",
                                   n, lat, red, white, guess_count, n);
            end
        end
        n_tests++;
        if (game_lost !== 1'b1 || game_won !== 1'b0) begin
            n_fail++; $display("FAIL loss_flag got lost%b won%b want lost1 won0", game_lost, game_won);
        end
        new_game = 1'b1; tick(); new_game = 1'b0;
        n_tests++;
        if ({code, guess, red, white, guess_count, entry_idx, game_lost} !== '0) begin
            n_fail++; $display("FAIL loss_newgame got %h want 0",
                               {code, guess, red, white, guess_count, entry_idx, game_lost});
        end
        send_digit(5);
        n_tests++;
        if (entry_idx !== 2'd1 || code[2:0] !== 3'd5 || guess !== 12'h0) begin
            n_fail++; $display("FAIL loss_reload got idx%0d code%h want idx1 code 005", entry_idx, code);
        end
    endtask

    task automatic test_reset_mid_score();
        dig_t c;
        int seen;
        c = '{1, 2, 3, 4};
        do_reset();
        enter(c);
        enter(c);
        for (int k = 0; k < 3; k++) tick();
        resetn = 1'b0; tick(); resetn = 1'b1;
        n_tests++;
        if ({red, white, guess_count, busy, score_valid, code} !== '0) begin
            n_fail++; $display("FAIL midreset_regs got r%0d w%0d gc%0d busy%b code%h want 0",
                               red, white, guess_count, busy, code);
        end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (score_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL midreset_pulse got %0d want 0", seen); end
        send_digit(6);
        n_tests++;
        if (entry_idx !== 2'd1 || code[2:0] !== 3'd6) begin
            n_fail++; $display("FAIL midreset_state got idx%0d code%h want idx1 code 006", entry_idx, code);
        end
    endtask

    task automatic test_random();
        dig_t c, g;
        int r, w, lat, gc;
        bit won, lost, uniq;
        for (int game = 0; game < 8; game++) begin
            do_reset();
            do begin
                uniq = 1'b1;
                for (int i = 0; i < NP; i++) c[i] = int'($urandom_range(0, NCOL - 1));
`ifdef MM_UNIQUE_CODE_EN
                for (int i = 0; i < NP; i++)
                    for (int j = 0; j < i; j++)
                        if (c[i] == c[j]) uniq = 1'b0;
`endif
            end while (!uniq);
            enter(c);
            gc = 0; won = 1'b0; lost = 1'b0;
            while (!won && !lost) begin
                if ($urandom_range(0, 4) == 0) g = c;
                else for (int i = 0; i < NP; i++) g[i] = int'($urandom_range(0, NCOL - 1));
                model_score(c, g, r, w);
                gc++;
                won  = (r == NP);
                lost = !won && (gc == MG);
                enter(g);
                wait_score(lat);
                n_tests++;
                if (lat != NCOL + 1 || red !== 3'(r) || white !== 3'(w) || guess_count !== 4'(gc)
                    || game_won !== won || game_lost !== lost || entry_idx !== 2'd0) begin
                    n_fail++;
                    $display("FAIL rand_g%0d_n%0d got lat%0d r%0d w%0d gc%0d won%b lost%b want lat%0d r%0d w%0d gc%0d won%b lost%b",
                             game, gc, lat, red, white, guess_count, game_won, game_lost,
                             NCOL + 1, r, w, gc, won, lost);
                    won = 1'b1;
                end
            end
        end
    endtask

    task automatic test_code_entry_rule();
        dig_t c;
        do_reset();
        send_digit(5);
        send_digit(5);
`ifdef MM_UNIQUE_CODE_EN
        n_tests++;
        if (code_reject !== 1'b1 || entry_idx !== 2'd1) begin
            n_fail++; $display("FAIL uniq_reject got rej%b idx%0d want rej1 idx1", code_reject, entry_idx);
        end
        tick();
        n_tests++;
        if (code_reject !== 1'b0) begin n_fail++; $display("FAIL uniq_pulse got 1 want 0"); end
        send_digit(6); send_digit(7); send_digit(0);
        c = '{5, 6, 7, 0};
`else
        n_tests++;
        if (code_reject !== 1'b0 || entry_idx !== 2'd2) begin
            n_fail++; $display("FAIL dup_accept got rej%b idx%0d want rej0 idx2", code_reject, entry_idx);
        end
        send_digit(5); send_digit(5);
        c = '{5, 5, 5, 5};
`endif
        n_tests++;
        if (code !== pack(c) || entry_idx !== 2'd0) begin
            n_fail++; $display("FAIL code_complete got %h idx%0d want %h idx0", code, entry_idx, pack(c));
        end
        send_digit(5);
        n_tests++;
        if (guess[2:0] !== 3'd5 || entry_idx !== 2'd1) begin
            n_fail++; $display("FAIL code_to_guess got %h idx%0d want digit0=5 idx1", guess, entry_idx);
        end
    endtask

    initial begin
        resetn = 1'b0; data_valid = 1'b0; new_game = 1'b0; data_in = '0;
        test_reset();
        test_exact_win();
`ifndef MM_UNIQUE_CODE_EN
        test_swap();
        test_busy_ignore();
`endif
        test_loss();
        test_reset_mid_score();
        test_code_entry_rule();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
